// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers pixel/line position from VGA syncs and tracks lock
module vga_timing_receiver #(
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int H_VIS        = 640,
    parameter int V_VIS        = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pixel_en,
    input  logic       hs,
    input  logic       vs,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       pixel_valid,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] frame_count
);
    typedef enum logic [1:0] {SEARCH, HTRACK, VTRACK, LOCKED} state_t;

    localparam logic [9:0] HSS    = 10'(H_SYNC_START);
    localparam logic [9:0] HSS_M1 = 10'(H_SYNC_START - 1);
    localparam logic [9:0] HT_M1  = 10'(H_TOTAL - 1);
    localparam logic [9:0] VSS    = 10'(V_SYNC_START);
    localparam logic [9:0] VSS_M1 = 10'(V_SYNC_START - 1);
    localparam logic [9:0] VT_M1  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HV     = 10'(H_VIS);
    localparam logic [9:0] VV     = 10'(V_VIS);

    state_t     r_state, w_state;
    logic [9:0] r_hcount, r_vcount, w_hcount, w_vcount;
    logic       r_hs_d, r_vs_d;
    logic [7:0] r_frame_count, w_frame_count;
    logic       r_locked, r_pixel_valid, r_h_err, r_v_err;
    logic       w_hs_fall, w_vs_fall, w_h_align, w_v_align, w_h_wrap;
    logic       w_h_err, w_v_err;

    assign DrawX       = r_hcount;
    assign DrawY       = r_vcount;
    assign locked      = r_locked;
    assign pixel_valid = r_pixel_valid;
    assign h_err       = r_h_err;
    assign v_err       = r_v_err;
    assign frame_count = r_frame_count;

    // Next-state: free-running counters, then the hs rule, then the vs rule on the state the hs rule produced
    always_comb begin
        w_hs_fall     = pixel_en & r_hs_d & ~hs;
        w_vs_fall     = pixel_en & r_vs_d & ~vs;
        w_h_align     = r_hcount == HSS_M1;
        w_h_wrap      = r_hcount == HT_M1;
        w_v_align     = (r_vcount == VSS_M1) && w_h_wrap;
        w_state       = r_state;
        w_hcount      = pixel_en ? (w_h_wrap ? 10'd0 : r_hcount + 10'd1) : r_hcount;
        w_vcount      = (pixel_en && w_h_wrap) ? ((r_vcount == VT_M1) ? 10'd0 : r_vcount + 10'd1) : r_vcount;
        w_frame_count = r_frame_count;
        w_h_err       = 1'b0;
        w_v_err       = 1'b0;
        if (w_hs_fall && (r_state == SEARCH || !w_h_align)) begin
            w_hcount = HSS;
            w_vcount = r_vcount;
            w_state  = HTRACK;
            w_h_err  = r_state != SEARCH;
        end else if (pixel_en && r_state == LOCKED && hs && r_hcount == HSS) begin
            w_h_err = 1'b1;
            w_state = SEARCH;
        end
        if (w_vs_fall) begin
            case (w_state)
                HTRACK: begin
                    w_vcount = VSS;
                    w_state  = VTRACK;
                end
                VTRACK: begin
                    if (w_v_align) begin
                        w_state = LOCKED;
                    end else begin
                        w_v_err  = 1'b1;
                        w_vcount = VSS;
                    end
                end
                LOCKED: begin
                    if (w_v_align) begin
                        w_frame_count = r_frame_count + 8'd1;
                    end else begin
                        w_v_err  = 1'b1;
                        w_vcount = VSS;
                        w_state  = VTRACK;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters and all outputs registered together so they change on the same edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= SEARCH;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hs_d        <= 1'b1;
            r_vs_d        <= 1'b1;
            r_frame_count <= '0;
            r_locked      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_h_err       <= 1'b0;
            r_v_err       <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hcount      <= w_hcount;
            r_vcount      <= w_vcount;
            r_hs_d        <= pixel_en ? hs : r_hs_d;
            r_vs_d        <= pixel_en ? vs : r_vs_d;
            r_frame_count <= w_frame_count;
            r_locked      <= w_state == LOCKED;
            r_pixel_valid <= (w_state == LOCKED) && (w_hcount < HV) && (w_vcount < VV);
            r_h_err       <= w_h_err;
            r_v_err       <= w_v_err;
        end
    end
endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver: directed vectors plus a scaled-down sync generator for lock/error scenarios
module tb_vga_timing_receiver;
    localparam int HT  = 16;
    localparam int HSS = 12;
    localparam int VT  = 8;
    localparam int VSS = 6;
    localparam int HV  = 10;
    localparam int VV  = 5;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       pixel_en = 1'b0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic [9:0] DrawX, DrawY;
    logic       pixel_valid, locked, h_err, v_err;
    logic [7:0] frame_count;

    vga_timing_receiver #(
        .H_TOTAL(HT), .H_SYNC_START(HSS), .V_TOTAL(VT),
        .V_SYNC_START(VSS), .H_VIS(HV), .V_VIS(VV)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en), .hs(hs), .vs(vs),
        .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid), .locked(locked),
        .h_err(h_err), .v_err(v_err), .frame_count(frame_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit rst, pe, hs, vs;
        int x, y;
        bit l, pv, he, ve;
        int fc;
    } vec_t;
    vec_t vec[14];

    int checks = 0, failures = 0;
    int herr_cnt = 0, verr_cnt = 0, xy_bad = 0, pv_bad = 0;
    int gx = 0, gy = 0, jump_line = -1, vjump = -1, kill_line = -1;
    bit half_rate = 1, track_xy = 0, track_pv = 0, vs_prev = 1, vs_fell = 0;
    bit s_herr, s_verr, s_locked, s_pv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit p);
        Reset = r;
        pixel_en = p;
        @(posedge Clk);
        #1;
        if (h_err) herr_cnt++;
        if (v_err) verr_cnt++;
    endtask

    task automatic xy_cmp();
        if (track_xy && (int'(DrawX) != gx || int'(DrawY) != gy)) xy_bad++;
        if (track_pv && pixel_valid != (gx < HV && gy < VV)) pv_bad++;
    endtask

    task automatic pix();
        if (gy == jump_line && gx == HSS - 5) begin
            gx = HSS;
            jump_line = -1;
        end else begin
            gx = (gx == HT - 1) ? 0 : gx + 1;
            if (gx == 0) gy = (gy == VT - 1) ? 0 : gy + 1;
        end
        if (gx == 0 && gy == vjump) begin
            gy = VSS;
            vjump = -1;
        end
        hs = (gy == kill_line) || !(gx >= HSS && gx < HSS + 2);
        vs = !(gy >= VSS && gy < VSS + 2);
        vs_fell = vs_prev && !vs;
        vs_prev = vs;
        tick(0, 1);
        s_herr = h_err;
        s_verr = v_err;
        s_locked = locked;
        s_pv = pixel_valid;
        xy_cmp();
        if (half_rate) begin
            tick(0, 0);
            xy_cmp();
        end
    endtask

    task automatic run_to(input int x, input int y);
        int budget = 2 * HT * VT;
        do begin
            pix();
            budget--;
        end while (!(gx == x && gy == y) && budget > 0);
        if (!(gx == x && gy == y)) begin
            checks++;
            failures++;
            $display("FAIL run_to_timeout actual=%0d,%0d required=%0d,%0d", gx, gy, x, y);
        end
    endtask

    task automatic run_vs(input int n);
        int seen = 0;
        int budget = (n + 1) * HT * VT;
        while (seen < n && budget > 0) begin
            pix();
            if (vs_fell) seen++;
            budget--;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL run_vs_timeout actual=%0d required=%0d", seen, n);
        end
    endtask

    initial begin
        int e0;
        vec[0]  = '{1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vec[1]  = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0};
        vec[2]  = '{0, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0};
        vec[3]  = '{0, 1, 0, 1, 12, 0, 0, 0, 0, 0, 0};
        vec[4]  = '{0, 0, 1, 1, 12, 0, 0, 0, 0, 0, 0};
        vec[5]  = '{0, 1, 1, 1, 13, 0, 0, 0, 0, 0, 0};
        vec[6]  = '{0, 1, 1, 0, 14, 6, 0, 0, 0, 0, 0};
        vec[7]  = '{0, 1, 0, 0, 12, 6, 0, 0, 1, 0, 0};
        vec[8]  = '{0, 0, 0, 0, 12, 6, 0, 0, 0, 0, 0};
        vec[9]  = '{0, 1, 1, 1, 13, 6, 0, 0, 0, 0, 0};
        vec[10] = '{0, 1, 1, 1, 14, 6, 0, 0, 0, 0, 0};
        vec[11] = '{0, 1, 0, 0, 12, 6, 0, 0, 1, 0, 0};
        vec[12] = '{0, 1, 1, 1, 13, 6, 0, 0, 0, 0, 0};
        vec[13] = '{0, 1, 1, 0, 14, 6, 0, 0, 0, 1, 0};
        for (int i = 0; i < 14; i++) begin
            hs = vec[i].hs;
            vs = vec[i].vs;
            tick(vec[i].rst, vec[i].pe);
            chk($sformatf("vec%0d_x", i), DrawX, vec[i].x);
            chk($sformatf("vec%0d_y", i), DrawY, vec[i].y);
            chk($sformatf("vec%0d_locked", i), locked, vec[i].l);
            chk($sformatf("vec%0d_pv", i), pixel_valid, vec[i].pv);
            chk($sformatf("vec%0d_herr", i), h_err, vec[i].he);
            chk($sformatf("vec%0d_verr", i), v_err, vec[i].ve);
            chk($sformatf("vec%0d_fc", i), frame_count, vec[i].fc);
        end

        // Ideal frames from an offset start: lock on second vs fall, count on third
        hs = 1;
        vs = 1;
        tick(1, 0);
        gx = 5;
        gy = 3;
        vs_prev = 1;
        run_vs(1);
        chk("a_locked_vs1", locked, 0);
        chk("a_y_vs1", DrawY, gy);
        track_xy = 1;
        run_vs(1);
        chk("a_locked_vs2", locked, 1);
        track_pv = 1;
        run_vs(1);
        chk("a_fc_vs3", frame_count, 1);
        track_pv = 0;
        chk("a_pv_map", pv_bad, 0);

        // hs fall four pixels early on one line
        e0 = herr_cnt;
        jump_line = 2;
        run_to(HSS, 2);
        chk("b_herr", s_herr, 1);
        chk("b_locked", s_locked, 0);
        run_to(0, 3);
        chk("b_pv", s_pv, 0);
        run_vs(1);
        chk("b_locked_vs1", locked, 0);
        run_vs(1);
        chk("b_locked_vs2", locked, 1);
        chk("b_herr_cnt", herr_cnt - e0, 1);

        // hs missing for a whole line
        e0 = herr_cnt;
        kill_line = 2;
        run_to(HSS + 1, 2);
        chk("c_herr", s_herr, 1);
        chk("c_locked", s_locked, 0);
        kill_line = -1;
        run_vs(1);
        chk("c_locked_vs1", locked, 0);
        run_vs(1);
        chk("c_locked_vs2", locked, 1);
        chk("c_herr_cnt", herr_cnt - e0, 1);

        // vs fall at the wrong line
        e0 = verr_cnt;
        vjump = 3;
        run_to(0, VSS);
        chk("d_verr", s_verr, 1);
        chk("d_y", DrawY, VSS);
        chk("d_locked", s_locked, 0);
        pix();
        chk("d_verr_clear", v_err, 0);
        chk("d_verr_cnt", verr_cnt - e0, 1);
        run_vs(1);
        chk("d_relock", locked, 1);
        chk("d_fc", frame_count, 1);

        // Reset mid-frame while locked, pixel_en low
        run_to(5, 2);
        chk("e_pv_before", pixel_valid, 1);
        track_xy = 0;
        tick(1, 0);
        chk("e_x", DrawX, 0);
        chk("e_y", DrawY, 0);
        chk("e_locked", locked, 0);
        chk("e_pv", pixel_valid, 0);
        chk("e_fc", frame_count, 0);
        for (int i = 0; i < 5; i++) tick(0, 0);
        chk("e_x_hold", DrawX, 0);
        chk("e_y_hold", DrawY, 0);
        run_vs(1);
        chk("e_locked_vs1", locked, 0);
        track_xy = 1;
        run_vs(1);
        chk("e_locked_vs2", locked, 1);
        chk("e_fc_relock", frame_count, 0);

        // 256 aligned frames with pixel_en held high: frame_count wraps
        half_rate = 0;
        e0 = herr_cnt + verr_cnt;
        run_vs(255);
        chk("f_fc_255", frame_count, 255);
        run_vs(1);
        chk("f_fc_wrap", frame_count, 0);
        chk("f_no_err", herr_cnt + verr_cnt - e0, 0);
        chk("f_locked", locked, 1);
        chk("xy_track", xy_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
